// File: rtl/div_seq_ctrl_if.sv
// div_seq_ctrl_if: divide request/result bundle
//   master: drives start, is_signed, srca, srcb; observes busy, done, quotient, remainder, overflow
//   slave : the divide controller side
interface div_seq_ctrl_if #(parameter int WIDTH = 32);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] srca;
   logic [WIDTH-1:0] srcb;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             overflow;
   modport master(output start, is_signed, srca, srcb,
                  input busy, done, quotient, remainder, overflow);
   modport slave(input start, is_signed, srca, srcb,
                 output busy, done, quotient, remainder, overflow);
endinterface

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multicycle non-restoring integer divide controller (signed/unsigned)
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of div_seq_ctrl_if (start/operands in, busy/done/results out)
module div_seq_ctrl #(parameter int WIDTH = 32) (
   input logic          clk,
   input logic          rst,
   div_seq_ctrl_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_a, r_b, r_q, r_quo, r_rem, w_mag_a, w_mag_b, w_rm, w_min;
   logic [WIDTH:0]   r_r, w_r_new, w_bx;
   logic [CW-1:0]    r_cnt;
   logic             r_ovf, r_a_neg, r_q_neg, w_div0, w_sovf, w_sa, w_sb;
   assign w_min   = {1'b1, {(WIDTH-1){1'b0}}};
   assign w_div0  = bus.srcb == '0;
   assign w_sovf  = bus.is_signed && bus.srca == w_min && bus.srcb == '1;
   assign w_sa    = bus.is_signed & bus.srca[WIDTH-1];
   assign w_sb    = bus.is_signed & bus.srcb[WIDTH-1];
   assign w_mag_a = w_sa ? -bus.srca : bus.srca;
   assign w_mag_b = w_sb ? -bus.srcb : bus.srcb;
   assign w_bx    = {1'b0, r_b};
   // one non-restoring step: shift in the next dividend bit, add or subtract by remainder sign
   assign w_r_new = {r_r[WIDTH-1:0], r_a[WIDTH-1]} + (r_r[WIDTH] ? w_bx : -w_bx);
   // final correction of a negative partial remainder; only the low WIDTH bits survive
   assign w_rm    = r_r[WIDTH] ? r_r[WIDTH-1:0] + r_b : r_r[WIDTH-1:0];
   assign bus.busy      = r_state != IDLE;
   assign bus.done      = r_state == DONE;
   assign bus.quotient  = r_quo;
   assign bus.remainder = r_rem;
   assign bus.overflow  = r_ovf;
   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = !bus.start ? IDLE : (w_div0 || w_sovf) ? DONE : ITER;
         ITER:    w_next = r_cnt == CW'(1) ? FIX : ITER;
         FIX:     w_next = DONE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_q     <= '0;
         r_r     <= '0;
         r_cnt   <= '0;
         r_quo   <= '0;
         r_rem   <= '0;
         r_ovf   <= 1'b0;
         r_a_neg <= 1'b0;
         r_q_neg <= 1'b0;
      end else begin
         case (r_state)
            IDLE:
               if (bus.start) begin
                  if (w_div0 || w_sovf) begin
                     r_quo <= '0;
                     r_rem <= w_div0 ? bus.srca : '0;
                     r_ovf <= 1'b1;
                  end else begin
                     r_a     <= w_mag_a;
                     r_b     <= w_mag_b;
                     r_r     <= '0;
                     r_cnt   <= CW'(WIDTH);
                     r_ovf   <= 1'b0;
                     r_a_neg <= w_sa;
                     r_q_neg <= w_sa ^ w_sb;
                  end
               end
            ITER: begin
               r_r   <= w_r_new;
               r_a   <= r_a << 1;
               r_q   <= {r_q[WIDTH-2:0], ~w_r_new[WIDTH]};
               r_cnt <= r_cnt - CW'(1);
            end
            FIX: begin
               r_quo <= r_q_neg ? -r_q : r_q;
               r_rem <= r_a_neg ? -w_rm : w_rm;
            end
            default: ;
         endcase
      end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed and randomized checks of div_seq_ctrl against an arithmetic model
module tb_div_seq_ctrl;
   localparam int W = 32;
   localparam logic [W-1:0] MIN = 32'h8000_0000;
   logic clk = 1'b0, rst = 1'b1;
   int   checks = 0, errors = 0;
   div_seq_ctrl_if #(.WIDTH(W)) bus();
   div_seq_ctrl #(.WIDTH(W)) dut(.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_res(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] q, output logic [W-1:0] r, output logic o,
                            output logic special);
      special = (b == 0) || (sg && a == MIN && b == '1);
      o = special;
      if (b == 0) begin q = '0; r = a; end
      else if (special) begin q = '0; r = '0; end
      else if (sg) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
      else begin q = a / b; r = a % b; end
   endtask

   // reference timeline: m_cnt counts cycles since acceptance, 0 when idle
   int         m_cnt = 0, m_lat = 0;
   logic [W-1:0] m_q = '0, m_r = '0, m_pq, m_pr;
   logic       m_o = 1'b0, m_po, m_sp;
   always @(negedge clk) begin
      if (rst) begin
         m_cnt = 0; m_q = '0; m_r = '0; m_o = 1'b0;
      end else if (m_cnt != 0) begin
         if (m_cnt == m_lat) m_cnt = 0;
         else begin
            m_cnt++;
            if (m_cnt == m_lat) begin m_q = m_pq; m_r = m_pr; m_o = m_po; end
         end
      end else if (bus.start) begin
         model_res(bus.is_signed, bus.srca, bus.srcb, m_pq, m_pr, m_po, m_sp);
         m_lat = m_sp ? 1 : W + 2;
         m_cnt = 1;
         if (m_sp) begin m_q = m_pq; m_r = m_pr; m_o = m_po; end
         else m_o = 1'b0;
      end
      chk("busy", bus.busy, m_cnt != 0);
      chk("done", bus.done, m_cnt != 0 && m_cnt == m_lat);
      chk("quotient", bus.quotient, m_q);
      chk("remainder", bus.remainder, m_r);
      chk("overflow", bus.overflow, m_o);
   end

   task automatic run(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                      input bit lit, input logic [W-1:0] eq, input logic [W-1:0] er,
                      input logic eo, input int elat, input int poke_at, input int rst_at,
                      input bit sod);
      int n;
      @(negedge clk); #1;
      bus.start = 1'b1; bus.is_signed = sg; bus.srca = a; bus.srcb = b;
      @(negedge clk); #1;
      bus.start = 1'b0; bus.srca = $urandom; bus.srcb = $urandom; bus.is_signed = $urandom_range(0, 1);
      n = 1;
      while (!bus.done && n < 60) begin
         if (n == rst_at) begin
            rst = 1'b1; #1;
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_q", bus.quotient, 0);
            chk("rst_r", bus.remainder, 0);
            chk("rst_ovf", bus.overflow, 0);
            @(negedge clk); #1;
            rst = 1'b0;
            return;
         end
         bus.start = (n == poke_at);
         if (bus.start) begin bus.srca = $urandom; bus.srcb = $urandom | 1; end
         @(negedge clk); #1;
         n++;
      end
      bus.start = 1'b0;
      chk("done_seen", bus.done, 1);
      if (lit) begin
         chk("latency", n, elat);
         chk("lit_q", bus.quotient, eq);
         chk("lit_r", bus.remainder, er);
         chk("lit_ovf", bus.overflow, eo);
      end
      if (sod) begin
         bus.start = 1'b1; bus.srca = $urandom; bus.srcb = $urandom;
         @(negedge clk); #1;
         bus.start = 1'b0;
      end
   endtask

   logic [W-1:0] ra, rb;
   logic         rs;
   initial begin
      bus.start = 1'b0; bus.is_signed = 1'b0; bus.srca = '0; bus.srcb = '0;
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      run(0, 100, 7, 1, 14, 2, 0, 34, 0, 0, 0);
      run(1, -32'sd7, 2, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, 34, 0, 0, 0);
      run(1, 7, -32'sd2, 1, 32'hFFFF_FFFD, 1, 0, 34, 0, 0, 0);
      run(0, 32'h1234_5678, 0, 1, 0, 32'h1234_5678, 1, 1, 0, 0, 0);
      run(1, 32'h1234_5678, 0, 1, 0, 32'h1234_5678, 1, 1, 0, 0, 0);
      run(1, MIN, '1, 1, 0, 0, 1, 1, 0, 0, 0);
      run(0, MIN, '1, 1, 0, MIN, 0, 34, 0, 0, 1);
      run(0, 100, 7, 1, 14, 2, 0, 34, 10, 0, 0);
      run(0, 100, 7, 0, 0, 0, 0, 0, 0, 15, 0);
      run(0, 9, 3, 1, 3, 0, 0, 34, 0, 0, 0);
      run(1, 0, 5, 1, 0, 0, 0, 34, 0, 0, 0);
      run(1, -32'sd9, -32'sd4, 1, 2, 32'hFFFF_FFFF, 0, 34, 0, 0, 0);
      for (int i = 0; i < 150; i++) begin
         rs = $urandom_range(0, 1);
         case ($urandom_range(0, 3))
            0: ra = MIN;
            1: ra = $urandom_range(0, 50);
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 5))
            0: rb = '0;
            1: rb = '1;
            2: rb = $urandom_range(1, 9);
            3: rb = -$urandom_range(1, 9);
            default: rb = $urandom >> $urandom_range(0, 31);
         endcase
         run(rs, ra, rb, 0, 0, 0, 0, 0,
             $urandom_range(0, 3) == 0 ? $urandom_range(2, 33) : 0,
             $urandom_range(0, 19) == 0 ? $urandom_range(1, 33) : 0,
             $urandom_range(0, 1));
      end
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
